alu_sequencer: RTL

Sequential front-end for the 16-bit arithmetic breadboard. It accepts one operation at a time over a valid/ready request channel and executes add, sub and mul in a single cycle. Div and mod run on an internal iterative signed restoring divider. The result is returned over a valid/ready response channel. It sits between the command source (testbench or future instruction decoder) and the result consumer, replacing the combinational loop-based divide/modulo path.

---
 rtl/alu_sequencer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Valid/ready ALU front-end: single-cycle add/sub/mul, iterative signed restoring
// divider for div/mod, registered result held until the consumer accepts it.
module alu_sequencer #(
   parameter int WIDTH     = 16,
   parameter int OUT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [3:0]           op_code,
   input  logic [WIDTH-1:0]     input1,
   input  logic [WIDTH-1:0]     input2,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [OUT_WIDTH-1:0] output1,
   output logic [1:0]           err_code,
   output logic                 busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXEC,
      S_DIV,
      S_FIX,
      S_DONE
   } state_t;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_MUL = 4'd2;
   localparam logic [3:0] OP_DIV = 4'd3;
   localparam logic [3:0] OP_MOD = 4'd4;

   localparam logic [1:0] ERR_OK   = 2'b00;
   localparam logic [1:0] ERR_OVF  = 2'b01;
   localparam logic [1:0] ERR_DIV0 = 2'b10;
   localparam logic [1:0] ERR_OP   = 2'b11;

   localparam int               CNT_W   = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

   state_t                       state_q, state_d;
   logic [3:0]                   op_q, op_d;
   logic signed [WIDTH-1:0]      a_q, a_d;
   logic signed [WIDTH-1:0]      b_q, b_d;
   logic [WIDTH-1:0]             quo_q, quo_d;
   logic [WIDTH:0]               rem_q, rem_d;
   logic [WIDTH:0]               dvs_q, dvs_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic [OUT_WIDTH-1:0]         out_q, out_d;
   logic [1:0]                   err_q, err_d;
   logic                         rsp_valid_q, rsp_valid_d;

   logic signed [OUT_WIDTH-1:0]  a_ext, b_ext;
   logic signed [OUT_WIDTH-1:0]  add_res, sub_res, mul_res;
   logic signed [OUT_WIDTH-1:0]  quo_mag, rem_mag, quo_res, rem_res;
   logic [WIDTH:0]               rem_sh;
   logic                         add_ovf, sub_ovf;

   // True when a sign-extended result does not fit in a signed WIDTH-bit value.
   function automatic logic out_of_range(input logic [OUT_WIDTH-1:0] v);
      logic [OUT_WIDTH-WIDTH:0] hi;
      hi = v[OUT_WIDTH-1:WIDTH-1];
      return !((&hi) || !(|hi));
   endfunction

   always_comb begin
      a_ext   = OUT_WIDTH'(a_q);
      b_ext   = OUT_WIDTH'(b_q);
      add_res = a_ext + b_ext;
      sub_res = a_ext - b_ext;
      mul_res = a_ext * b_ext;
      add_ovf = out_of_range(add_res);
      sub_ovf = out_of_range(sub_res);
      // Magnitudes are zero-extended so that 2^(WIDTH-1) stays positive.
      quo_mag = OUT_WIDTH'(quo_q);
      rem_mag = OUT_WIDTH'(rem_q);
      quo_res = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -quo_mag : quo_mag;
      rem_res = a_q[WIDTH-1] ? -rem_mag : rem_mag;
      rem_sh  = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
   end

   // NOTE: every variable gets its default first so no path through the case
   // leaves one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      quo_d       = quo_q;
      rem_d       = rem_q;
      dvs_d       = dvs_q;
      cnt_d       = cnt_q;
      out_d       = out_q;
      err_d       = err_q;
      rsp_valid_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               op_d = op_code;
               a_d  = input1;
               b_d  = input2;
               if (op_code == OP_DIV || op_code == OP_MOD) begin
                  if (input2 == '0) begin
                     out_d   = '0;
                     err_d   = ERR_DIV0;
                     state_d = S_DONE;
                  end else begin
                     quo_d   = input1[WIDTH-1] ? -input1 : input1;
                     dvs_d   = {1'b0, (input2[WIDTH-1] ? -input2 : input2)};
                     rem_d   = '0;
                     cnt_d   = CNT_MAX;
                     state_d = S_DIV;
                  end
               end else begin
                  state_d = S_EXEC;
               end
            end
         end

         S_EXEC: begin
            case (op_q)
               OP_ADD: begin
                  out_d = add_res;
                  err_d = add_ovf ? ERR_OVF : ERR_OK;
               end
               OP_SUB: begin
                  out_d = sub_res;
                  err_d = sub_ovf ? ERR_OVF : ERR_OK;
               end
               OP_MUL: begin
                  out_d = mul_res;
                  err_d = ERR_OK;
               end
               default: begin
                  out_d = '0;
                  err_d = ERR_OP;
               end
            endcase
            state_d = S_DONE;
         end

         S_DIV: begin
            // One restoring step: bring down the next dividend bit, subtract if it fits.
            if (rem_sh >= dvs_q) begin
               rem_d = rem_sh - dvs_q;
               quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = rem_sh;
               quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            if (cnt_q == '0) begin
               state_d = S_FIX;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         S_FIX: begin
            out_d   = (op_q == OP_MOD) ? rem_res : quo_res;
            err_d   = ERR_OK;
            state_d = S_DONE;
         end

         S_DONE: begin
            // rsp_valid is the registered image of DONE, so it rises one edge after entry.
            if (rsp_valid_q && rsp_ready) begin
               state_d = S_IDLE;
            end else begin
               rsp_valid_d = 1'b1;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples
   // the pre-edge values; the divider datapath is ordinary registers, so it is
   // cleared by reset like the rest of the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         quo_q       <= '0;
         rem_q       <= '0;
         dvs_q       <= '0;
         cnt_q       <= '0;
         out_q       <= '0;
         err_q       <= ERR_OK;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         quo_q       <= quo_d;
         rem_q       <= rem_d;
         dvs_q       <= dvs_d;
         cnt_q       <= cnt_d;
         out_q       <= out_d;
         err_q       <= err_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign req_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign rsp_valid = rsp_valid_q;
   assign output1   = out_q;
   assign err_code  = err_q;

endmodule
